// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: FSM states, queue entry
// layout and the NOP presented to decode when nothing is buffered.
package fetch_unit_pkg;

   typedef logic [31:0] DATA_BUS;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      FLUSH
   } fetch_state_t;

   localparam DATA_BUS NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      DATA_BUS     instr;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_instr_queue.sv
// Small synchronous FIFO of fetched {instr, pc} entries. Flush wins over
// push and pop so a redirect always leaves the queue empty next cycle.
module fetch_unit_instr_queue
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [AW:0]  count,
   output logic         empty,
   output logic         full
);

   fetch_entry_t  mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;
   assign count   = count_reg;
   assign head    = mem_reg[rd_ptr_reg];

   // Storage has no reset: stale contents are never visible while count is 0.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding imem request at a
// time, buffers responses and hands {instr, pc} to decode via valid/ready.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output DATA_BUS     instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int unsigned CW = $clog2(QDEPTH) + 1;

   fetch_state_t  state_reg;
   logic [31:0]   pc_reg;
   logic [31:0]   redirect_target;
   logic [3:0]    since_rst_reg;

   fetch_entry_t  q_push_data;
   fetch_entry_t  q_head;
   logic [CW-1:0] q_count;
   logic          q_empty;
   logic          q_full;
   logic          q_push;
   logic          q_pop;

   assign redirect_target = align_pc(redirect_pc);

   // Queue space is reserved when the request goes out, so a push never overflows.
   assign imem_req  = !rst && (state_reg == IDLE) && !q_full && !redirect_valid;
   assign imem_addr = pc_reg;

   assign q_push      = (state_reg == WAIT) && imem_rvalid && !redirect_valid;
   assign q_pop       = instr_valid && instr_ready;
   assign q_push_data = '{instr: imem_rdata, pc: pc_reg};

   assign instr_valid = !q_empty;
   assign instr       = q_empty ? NOP_INSTR : q_head.instr;
   assign instr_pc    = q_empty ? 32'h0 : q_head.pc;

   fetch_unit_instr_queue #(
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (q_push),
      .push_data (q_push_data),
      .pop       (q_pop),
      .flush     (redirect_valid),
      .head      (q_head),
      .count     (q_count),
      .empty     (q_empty),
      .full      (q_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         pc_reg    <= RESET_PC;
      end else begin
         case (state_reg)
            IDLE: begin
               // A response here belongs to a request issued before reset.
               if (redirect_valid) begin
                  pc_reg <= redirect_target;
               end else if (imem_req) begin
                  state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  state_reg <= IDLE;
                  pc_reg    <= redirect_valid ? redirect_target : pc_reg + 32'd4;
               end else if (redirect_valid) begin
                  state_reg <= FLUSH;
                  pc_reg    <= redirect_target;
               end
            end
            FLUSH: begin
               if (redirect_valid) begin
                  pc_reg <= redirect_target;
               end
               if (imem_rvalid) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         since_rst_reg <= '0;
      end else if (since_rst_reg != 4'hF) begin
         since_rst_reg <= since_rst_reg + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(state_reg == IDLE && imem_rvalid) || since_rst_reg <= 4'd8);
         assert (q_count <= CW'(QDEPTH));
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written redirect/reset
// sequences and a randomized run against a queue-based reference model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          QD     = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC (RST_PC),
      .QDEPTH   (QD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   int checks_total  = 0;
   int checks_passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Memory model: one response, cur_lat cycles after the accepted request.
   int          mem_cnt = 0;
   int          cur_lat = 1;
   int          widx    = 0;
   logic [31:0] words [16];

   // Reference model: fetch pointer, outstanding/stale flags, entry queue.
   logic [31:0]  m_pc    = RST_PC;
   bit           m_out   = 1'b0;
   bit           m_stale = 1'b0;
   fetch_entry_t mq[$];

   logic        obs_req;
   logic [31:0] obs_addr;
   logic        obs_valid;
   logic [31:0] obs_instr;
   logic [31:0] obs_pc;

   task automatic cycle();
      logic        exp_req;
      bit          resp;
      imem_rvalid = (mem_cnt == 1);
      imem_rdata  = imem_rvalid ? ((widx < 16) ? words[widx] : $urandom()) : 32'hDEAD_BEEF;
      @(negedge clk);
      obs_req   = imem_req;
      obs_addr  = imem_addr;
      obs_valid = instr_valid;
      obs_instr = instr;
      obs_pc    = instr_pc;
      exp_req = !rst && !m_out && (mq.size() < QD) && !redirect_valid;
      check("model_req", {31'b0, obs_req}, {31'b0, exp_req});
      if (exp_req) check("model_addr", obs_addr, m_pc);
      check("model_valid", {31'b0, obs_valid}, {31'b0, mq.size() > 0});
      check("model_instr", obs_instr, (mq.size() > 0) ? mq[0].instr : NOP_INSTR);
      check("model_pc", obs_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
      @(posedge clk);
      #1;
      if (rst) begin
         m_pc = RST_PC; m_out = 1'b0; m_stale = 1'b0; mq.delete();
      end else begin
         resp = imem_rvalid && m_out;
         if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc & ~32'h3;
            if (m_out && !imem_rvalid) m_stale = 1'b1;
         end else begin
            if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
            if (resp && !m_stale) begin
               mq.push_back('{instr: imem_rdata, pc: m_pc});
               m_pc = m_pc + 32'd4;
            end
         end
         if (resp) begin m_out = 1'b0; m_stale = 1'b0; end
         if (exp_req) m_out = 1'b1;
      end
      if (imem_rvalid) begin mem_cnt = 0; widx++; end
      else if (mem_cnt > 1) mem_cnt--;
      if (obs_req) mem_cnt = cur_lat;
   endtask

   task automatic check_obs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pc);
      check({tag, "_req"}, {31'b0, obs_req}, {31'b0, e_req});
      if (e_req) check({tag, "_addr"}, obs_addr, e_addr);
      check({tag, "_valid"}, {31'b0, obs_valid}, {31'b0, e_valid});
      check({tag, "_instr"}, obs_instr, e_instr);
      check({tag, "_pc"}, obs_pc, e_pc);
   endtask

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic rd, input logic er, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ei, input logic [31:0] ep);
      vec_t v;
      v.rst = r; v.rdy = rd; v.e_req = er; v.e_addr = ea;
      v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
      return v;
   endfunction

   vec_t vt [17];

   initial begin
      for (int i = 0; i < 16; i++) words[i] = 32'h0100_0013 + (i << 20);
      words[0] = 32'h0050_0093; words[1] = 32'h00A0_0113; words[2] = 32'h0020_81B3;
      words[3] = 32'h0030_8213; words[4] = 32'h0041_0293;

      // 1-cycle memory, decode always ready, then stall with a full queue.
      vt[0]  = mk(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, NOP_INSTR, 32'h0);
      vt[1]  = mk(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, NOP_INSTR, 32'h0);
      vt[2]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, NOP_INSTR, 32'h0);
      vt[3]  = mk(1'b0, 1'b1, 1'b1, 32'h104, 1'b1, words[0],  32'h100);
      vt[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, NOP_INSTR, 32'h0);
      vt[5]  = mk(1'b0, 1'b1, 1'b1, 32'h108, 1'b1, words[1],  32'h104);
      vt[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, NOP_INSTR, 32'h0);
      vt[7]  = mk(1'b0, 1'b1, 1'b1, 32'h10C, 1'b1, words[2],  32'h108);
      vt[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, NOP_INSTR, 32'h0);
      vt[9]  = mk(1'b0, 1'b0, 1'b1, 32'h110, 1'b1, words[3],  32'h10C);
      vt[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, words[3],  32'h10C);
      vt[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, words[3],  32'h10C);
      vt[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, words[3],  32'h10C);
      vt[13] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, words[3],  32'h10C);
      vt[14] = mk(1'b0, 1'b0, 1'b1, 32'h114, 1'b1, words[4],  32'h110);
      vt[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, words[4],  32'h110);
      vt[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, words[4],  32'h110);

      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
      imem_rvalid = 1'b0; imem_rdata = 32'h0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         rst = vt[i].rst; instr_ready = vt[i].rdy; cur_lat = 1;
         cycle();
         $display("row %0d: req=%b addr=%h valid=%b instr=%h pc=%h",
                  i, obs_req, obs_addr, obs_valid, obs_instr, obs_pc);
         check_obs($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr,
                   vt[i].e_valid, vt[i].e_instr, vt[i].e_pc);
      end

      // Redirect one cycle after a request with 3-cycle memory latency.
      rst = 1'b1; instr_ready = 1'b1;
      cycle(); cycle();
      check_obs("rst_vals", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0);
      rst = 1'b0; cur_lat = 3;
      cycle(); check_obs("flush_req", 1'b1, 32'h100, 1'b0, NOP_INSTR, 32'h0);
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      cycle(); check_obs("flush_redir", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0);
      redirect_valid = 1'b0;
      cycle(); check_obs("flush_wait", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0);
      cycle(); check_obs("flush_stale", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0);
      cur_lat = 1;
      cycle(); check_obs("flush_newreq", 1'b1, 32'h200, 1'b0, NOP_INSTR, 32'h0);
      cycle(); check_obs("flush_resp", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0);
      instr_ready = 1'b0;
      cycle(); check_obs("flush_head", 1'b1, 32'h204, 1'b1, words[7], 32'h200);

      // Redirect and response in the same WAIT cycle.
      redirect_valid = 1'b1; redirect_pc = 32'h3F2;
      cycle(); check_obs("same_cyc", 1'b0, 32'h0, 1'b1, words[7], 32'h200);
      redirect_valid = 1'b0; cur_lat = 3;
      cycle(); check_obs("same_next", 1'b1, 32'h3F0, 1'b0, NOP_INSTR, 32'h0);

      // Reset while a request is outstanding; its late response must be ignored.
      rst = 1'b1;
      cycle(); cycle();
      check_obs("rstwait_hold", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0);
      rst = 1'b0; cur_lat = 1; instr_ready = 1'b1;
      cycle(); check_obs("rstwait_req", 1'b1, RST_PC, 1'b0, NOP_INSTR, 32'h0);
      cycle(); check_obs("rstwait_resp", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0);
      cycle(); check_obs("rstwait_head", 1'b1, RST_PC + 32'd4, 1'b1, words[10], RST_PC);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         if (rst) rst = (mem_cnt > 1);
         else     rst = ($urandom_range(0, 199) == 0);
         redirect_valid = ($urandom_range(0, 7) == 0);
         redirect_pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF5 : $urandom();
         instr_ready    = ($urandom_range(0, 3) != 0);
         cur_lat        = $urandom_range(1, 4);
         cycle();
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
